// File: rtl/powerlink_led_sequencer_pkg.sv
// Shared definitions for the POWERLINK status/error LED sequencer:
// mode codes, sequencer states and phase lengths in ticks.
package powerlink_led_sequencer_pkg;

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_FLICKER = 3'd2;
    localparam logic [2:0] MODE_BLINK   = 3'd3;
    localparam logic [2:0] MODE_FLASH1  = 3'd4;
    localparam logic [2:0] MODE_FLASH2  = 3'd5;
    localparam logic [2:0] MODE_FLASH3  = 3'd6;
    localparam logic [2:0] MODE_RSVD    = 3'd7;

    localparam logic [4:0] LEN_FLICKER = 5'd1;
    localparam logic [4:0] LEN_FLASH   = 5'd4;
    localparam logic [4:0] LEN_LONG    = 5'd20;

    typedef enum logic [1:0] {
        OFF_STEADY,
        ON_STEADY,
        PHASE_ON,
        PHASE_OFF
    } led_state_t;

    // On-length and short off-length are equal for every blinking mode.
    function automatic logic [4:0] phase_len(input logic [2:0] mode);
        return (mode == MODE_FLICKER) ? LEN_FLICKER : LEN_FLASH;
    endfunction

    function automatic logic [1:0] last_flash(input logic [2:0] mode);
        case (mode)
            MODE_FLASH2: return 2'd1;
            MODE_FLASH3: return 2'd2;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic has_long_off(input logic [2:0] mode);
        return (mode == MODE_FLASH1) || (mode == MODE_FLASH2) || (mode == MODE_FLASH3);
    endfunction

endpackage

// File: rtl/powerlink_led_fsm.sv
// Per-LED pattern sequencer: steady on/off or repeating on/off phases
// timed in pattern ticks, with a registered LED drive.
module powerlink_led_fsm
    import powerlink_led_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       i_restart,
    input  logic [2:0] i_mode,
    output logic       o_led
);

    led_state_t r_state, w_state_next;
    logic [1:0] r_flash, w_flash_next;
    logic [4:0] r_phase, w_phase_next;
    logic       r_led;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OFF_STEADY;
            r_flash <= 2'd0;
            r_phase <= 5'd0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_flash <= w_flash_next;
            r_phase <= w_phase_next;
            r_led   <= (r_state == ON_STEADY) || (r_state == PHASE_ON);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_flash_next = r_flash;
        w_phase_next = r_phase;
        if (i_restart) begin
            // A restart swallows any coincident tick.
            w_flash_next = 2'd0;
            w_phase_next = 5'd0;
            case (i_mode)
                MODE_OFF, MODE_RSVD: w_state_next = OFF_STEADY;
                MODE_ON:             w_state_next = ON_STEADY;
                default: begin
                    w_state_next = PHASE_ON;
                    w_phase_next = phase_len(i_mode);
                end
            endcase
        end else if (i_tick && (r_state == PHASE_ON || r_state == PHASE_OFF)) begin
            if (r_phase == 5'd1) begin
                if (r_state == PHASE_ON) begin
                    w_state_next = PHASE_OFF;
                    w_phase_next = (has_long_off(i_mode) && r_flash == last_flash(i_mode))
                                   ? LEN_LONG : phase_len(i_mode);
                end else begin
                    w_state_next = PHASE_ON;
                    w_phase_next = phase_len(i_mode);
                    w_flash_next = (r_flash == last_flash(i_mode)) ? 2'd0 : r_flash + 2'd1;
                end
            end else begin
                w_phase_next = r_phase - 5'd1;
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/powerlink_led_sequencer.sv
// Avalon-MM controlled POWERLINK status/error LED sequencer: mode registers,
// shared pattern tick and one sequencer per LED.
module powerlink_led_sequencer
    import powerlink_led_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        led_status,
    output logic        led_error
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          w_wr;
    logic [1:0]    w_led;
    logic [1:0][2:0] w_mode;
    logic          w_unused_wdata;

    assign w_tick         = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Index 0 drives the status LED, index 1 the error LED.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_led
            logic [2:0] r_mode;
            logic       w_sel;
            logic       w_restart;
            logic [2:0] w_mode_eff;

            assign w_sel      = w_wr && (address == 2'(gi));
            assign w_restart  = w_sel && (writedata[2:0] != r_mode);
            assign w_mode_eff = w_restart ? writedata[2:0] : r_mode;
            assign w_mode[gi] = r_mode;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mode <= MODE_OFF;
                end else if (w_sel) begin
                    r_mode <= writedata[2:0];
                end
            end

            powerlink_led_fsm u_fsm (
                .clk       (clk),
                .reset     (reset),
                .i_tick    (w_tick),
                .i_restart (w_restart),
                .i_mode    (w_mode_eff),
                .o_led     (w_led[gi])
            );
        end
    endgenerate

    assign led_status = w_led[0];
    assign led_error  = w_led[1];

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {29'd0, w_mode[0]};
            2'd1:    readdata = {29'd0, w_mode[1]};
            2'd2:    readdata = {30'd0, led_error, led_status};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/powerlink_led_sequencer.md
POWERLINK_LED_SEQUENCER -- requirements
Module: powerlink_led_sequencer

Interface
REQ-001 Parameter: TICK_CYCLES, default 2500000, clk cycles per 50 ms pattern tick (50 MHz clk).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  2  Avalon-MM word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  32  write data; bits [2:0] used.
REQ-008 readdata  output  32  read data, zero wait states.
REQ-009 led_status  output  1  POWERLINK status LED drive (1 = lit).
REQ-010 led_error  output  1  POWERLINK error LED drive (1 = lit).

Function
REQ-011 Register map SHALL be: addr 0 status mode[2:0] RW; addr 1 error mode[2:0] RW; addr 2 {30'b0, led_error, led_status} RO; addr 3 reads 0, writes ignored.
REQ-012 Write SHALL occur when chipselect=1 and write_n=0; register updates on that edge.
REQ-013 readdata SHALL be combinational from address, upper bits zero.
REQ-014 Tick generator SHALL emit a one-cycle tick every TICK_CYCLES cycles, free-running, shared by both LEDs.
REQ-015 Mode codes (ON/OFF phase lengths in ticks) SHALL be: 0 off; 1 on; 2 flicker 1/1 repeating; 3 blink 4/4 repeating; 4 single flash 4 on, 20 off; 5 double flash 4 on,4 off,4 on,20 off; 6 triple flash 4 on,4 off,4 on,4 off,4 on,20 off; 7 reserved, behaves as 0.
REQ-016 Each LED SHALL have its own sequencer FSM: OFF_STEADY, ON_STEADY, PHASE_ON, PHASE_OFF, with a flash counter (0..2) and a phase-tick down-counter (5 bits).
REQ-017 Modes 0/7 SHALL force OFF_STEADY (LED 0); mode 1 SHALL force ON_STEADY (LED 1).
REQ-018 Modes 2-6: PHASE_ON lasts the mode's on-length in ticks then enters PHASE_OFF; PHASE_OFF ends after short off (4 ticks, or 1 for flicker) while flashes remain, else after long off (20 ticks) with flash counter cleared, returning to PHASE_ON.
REQ-019 Phase counter SHALL decrement only on tick; phase ends on the tick decrementing it from 1; first phase after restart may be short by up to TICK_CYCLES-1 cycles.
REQ-020 A write changing a mode SHALL restart that LED's sequencer in PHASE_ON (flash counter 0) on the next cycle; writing the current value SHALL NOT restart it.
REQ-021 A write to one mode register SHALL NOT disturb the other LED's sequence.
REQ-022 Write coinciding with tick: the new mode wins; the tick is not applied to the restarted phase.
REQ-023 LED outputs SHALL be registered: high exactly in ON_STEADY and PHASE_ON, one cycle after state change.

Reset
REQ-024 Reset SHALL clear both mode registers, tick counter, flash and phase counters; FSMs to OFF_STEADY.
REQ-025 During and after reset led_status=0, led_error=0; readdata at addr 0/1/2 = 0.
REQ-026 Reset mid-pattern SHALL abort it; sequence restarts only on a subsequent mode write.

Structure
REQ-027 Shared package SHALL hold mode code constants, FSM state enum, phase lengths (1, 4, 20 ticks).
REQ-028 One sub-module powerlink_led_fsm SHALL be instantiated twice (status, error); tick generator and register file in top.

Verification (TICK_CYCLES=10)
REQ-029 Reset, read addr 0,1,2 -> all 0; both LEDs 0.
REQ-030 Write addr 0 = 1 -> led_status=1 two cycles later, steady; led_error stays 0.
REQ-031 Write addr 1 = 3 -> led_error high 4 ticks (first possibly short), low 40 cycles, high 40 cycles, repeating.
REQ-032 Write addr 0 = 5 -> status pattern 40 on, 40 off, 40 on, 200 off cycles, repeating; addr 2 read tracks LED.
REQ-033 Mid double-flash, write addr 0 = 5 again -> no restart; then write 6 -> PHASE_ON immediately, three flashes.
REQ-034 Assert reset during triple flash -> LEDs 0 next cycle, modes read 0, no activity until rewritten.
